// File: rtl/mem_rsp_reader.sv
// mem_rsp_reader: forwards requests to a fixed-latency req/gnt memory and buffers every response.
// Optional MEM_RSP_READER_FALL_THROUGH_EN presents a return combinationally when the buffer is empty.
module mem_rsp_reader #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned BUF_DEPTH   = 2,
  parameter int unsigned CNT_W       = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_we_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic [CNT_W-1:0]      outstanding_o
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);

  logic [CNT_W-1:0]       outstanding_q;
  logic [CNT_W-1:0]       buf_cnt_q;
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [DATA_WIDTH-1:0]  buf_q [BUF_DEPTH];
  logic [MEM_LATENCY-1:0] sr_vld_q;
  logic [MEM_LATENCY-1:0] sr_we_q;

  logic                  credit_ok;
  logic                  gnt_hs;
  logic                  rsp_hs;
  logic                  ret_vld;
  logic [DATA_WIDTH-1:0] ret_data;
  logic                  buf_empty;
  logic                  buf_push;
  logic                  buf_pop;

  assign credit_ok   = (outstanding_q < DEPTH_C);
  assign mem_req_o   = req_valid_i & credit_ok;
  assign req_ready_o = mem_gnt_i & credit_ok;
  assign gnt_hs      = mem_req_o & mem_gnt_i;
  assign mem_addr_o  = req_addr_i;
  assign mem_we_o    = req_we_i;
  assign mem_wdata_o = req_wdata_i;

  assign ret_vld   = sr_vld_q[MEM_LATENCY-1];
  assign ret_data  = sr_we_q[MEM_LATENCY-1] ? '0 : mem_rdata_i;
  assign buf_empty = (buf_cnt_q == '0);

`ifdef MEM_RSP_READER_FALL_THROUGH_EN
  // An accepted bypass beat never occupies a buffer slot.
  logic bypass;
  assign bypass      = ret_vld & buf_empty;
  assign rsp_valid_o = ~buf_empty | bypass;
  assign rsp_data_o  = buf_empty ? ret_data : buf_q[rd_ptr_q];
  assign buf_push    = ret_vld & ~(bypass & rsp_ready_i);
  assign buf_pop     = ~buf_empty & rsp_ready_i;
`else
  assign rsp_valid_o = ~buf_empty;
  assign rsp_data_o  = buf_q[rd_ptr_q];
  assign buf_push    = ret_vld;
  assign buf_pop     = ~buf_empty & rsp_ready_i;
`endif

  assign rsp_hs        = rsp_valid_o & rsp_ready_i;
  assign outstanding_o = outstanding_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_vld_q <= '0;
      sr_we_q  <= '0;
    end else begin
      sr_vld_q[0] <= gnt_hs;
      sr_we_q[0]  <= req_we_i;
      for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
        sr_vld_q[i] <= sr_vld_q[i-1];
        sr_we_q[i]  <= sr_we_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else begin
      case ({gnt_hs, rsp_hs})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      assert (!(buf_push && (buf_cnt_q == DEPTH_C)));
      if (buf_push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (buf_pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({buf_push, buf_pop})
        2'b10:   buf_cnt_q <= buf_cnt_q + 1'b1;
        2'b01:   buf_cnt_q <= buf_cnt_q - 1'b1;
        default: buf_cnt_q <= buf_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (buf_push) buf_q[wr_ptr_q] <= ret_data;
  end

endmodule
